axis_pgroup_router: RTL and testbench

AXIS_PGROUP_ROUTER -- requirements
Module: axis_pgroup_router

---
 rtl/axis_pgroup_router.sv | 179 +++++++++++++++++
 tb/tb_axis_pgroup_router.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axis_pgroup_router.sv
// axis_pgroup_router
// Routes an AXI-Stream of pixel groups to IP_AMT image-processor channels.
// The first beat of each packet selects the channel through s_tdest_i. Every
// later beat of that packet follows the same channel, whatever its TDEST says.
// A packet with an out-of-range TDEST is accepted and discarded, and each
// discarded beat is counted. Each channel buffers beats in its own small FIFO,
// so back-pressure on one channel stalls only the packets routed to it.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   s_tdest_i        destination channel index of the incoming beat
//   s_tdata_i        incoming pixel group
//   s_tlast_i        end-of-packet marker
//   s_tvalid_i       slave valid
//   s_tready_o       slave ready
//   pgroup_o         per-channel FIFO head data, channel k at [k*IP_DATA_W +: IP_DATA_W]
//   pgroup_last_o    per-channel FIFO head TLAST
//   pgroup_valid_o   per-channel "FIFO not empty"
//   pgroup_ready_i   per-channel consumer ready; a beat pops on valid & ready
//   drop_cnt_o       saturating count of discarded beats
module axis_pgroup_router #(
    parameter int IP_AMT       = 4,
    parameter int IP_DATA_W    = 256,
    parameter int AXIS_TDEST_W = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXIS_TDEST_W-1:0]     s_tdest_i,
    input  logic [IP_DATA_W-1:0]        s_tdata_i,
    input  logic                        s_tlast_i,
    input  logic                        s_tvalid_i,
    output logic                        s_tready_o,
    output logic [IP_AMT*IP_DATA_W-1:0] pgroup_o,
    output logic [IP_AMT-1:0]           pgroup_last_o,
    output logic [IP_AMT-1:0]           pgroup_valid_o,
    input  logic [IP_AMT-1:0]           pgroup_ready_i,
    output logic [DROP_CNT_W-1:0]       drop_cnt_o
);

    localparam int CH_W = (IP_AMT > 1) ? $clog2(IP_AMT) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam logic [31:0] IP_AMT_L = 32'(IP_AMT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CH_W-1:0]         chan_r;
    logic [DROP_CNT_W-1:0]   drop_cnt_r;

    logic [CH_W-1:0]         dest_chan_s;
    logic [CH_W-1:0]         sel_chan_s;
    logic                    dest_ok_s;
    logic                    tready_s;
    logic                    accept_s;
    logic                    route_s;
    logic                    drop_s;
    logic [IP_AMT-1:0]       full_s;
    logic [IP_AMT-1:0]       empty_s;
    logic [IP_AMT-1:0]       push_s;
    logic [IP_AMT-1:0]       pop_s;

    // Decode the channel, derive ready and classify the accepted beat.
    // Ready looks only at pre-pop FIFO state, so it never depends on pgroup_ready_i.
    always_comb begin
        dest_ok_s   = (32'(s_tdest_i) < IP_AMT_L);
        dest_chan_s = s_tdest_i[CH_W-1:0];
        sel_chan_s  = (state_r == ROUTE) ? chan_r : dest_chan_s;
        tready_s    = 1'b0;
        if (rst) begin
            tready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dest_ok_s) begin
                        tready_s = ~full_s[dest_chan_s];
                    end else begin
                        tready_s = 1'b1;
                    end
                end
                ROUTE:   tready_s = ~full_s[chan_r];
                DROP:    tready_s = 1'b1;
                default: tready_s = 1'b0;
            endcase
        end
        accept_s = s_tvalid_i & tready_s;
        route_s  = accept_s & (((state_r == IDLE) & dest_ok_s) | (state_r == ROUTE));
        drop_s   = accept_s & (((state_r == IDLE) & ~dest_ok_s) | (state_r == DROP));
    end

    // One-hot write enable for the FIFO of the routed channel.
    always_comb begin
        push_s = {IP_AMT{1'b0}};
        if (route_s) begin
            push_s[sel_chan_s] = 1'b1;
        end else begin
            push_s = {IP_AMT{1'b0}};
        end
    end

    // Routing FSM, latched channel and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            chan_r     <= {CH_W{1'b0}};
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                if (s_tlast_i) begin
                    state_r <= IDLE;
                end else begin
                    case (state_r)
                        IDLE: begin
                            if (dest_ok_s) begin
                                state_r <= ROUTE;
                                chan_r  <= dest_chan_s;
                            end else begin
                                state_r <= DROP;
                            end
                        end
                        ROUTE:   state_r <= ROUTE;
                        DROP:    state_r <= DROP;
                        default: state_r <= IDLE;
                    endcase
                end
            end
            if (drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < IP_AMT; k++) begin : g_ch
        logic [IP_DATA_W:0] mem_r [FIFO_DEPTH];
        logic [PW-1:0]      wptr_r;
        logic [PW-1:0]      rptr_r;

        // The pointers carry one extra wrap bit, which tells full from empty.
        assign full_s[k]  = (wptr_r[PW-1] != rptr_r[PW-1]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
        assign empty_s[k] = (wptr_r == rptr_r);
        assign pop_s[k]   = ~empty_s[k] & pgroup_ready_i[k];

        // FIFO pointer update; push and pop may both happen in the same cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                wptr_r <= {PW{1'b0}};
                rptr_r <= {PW{1'b0}};
            end else begin
                if (push_s[k]) begin
                    wptr_r <= wptr_r + PW'(1);
                end
                if (pop_s[k]) begin
                    rptr_r <= rptr_r + PW'(1);
                end
            end
        end

        // FIFO storage of {tlast, tdata}; its contents do not matter while the FIFO is empty.
        always_ff @(posedge clk) begin
            if (push_s[k]) begin
                mem_r[wptr_r[AW-1:0]] <= {s_tlast_i, s_tdata_i};
            end
        end

        assign pgroup_o[k*IP_DATA_W +: IP_DATA_W] = mem_r[rptr_r[AW-1:0]][IP_DATA_W-1:0];
        assign pgroup_last_o[k]                   = mem_r[rptr_r[AW-1:0]][IP_DATA_W];
        assign pgroup_valid_o[k]                  = ~empty_s[k];
    end

    assign s_tready_o = tready_s;
    assign drop_cnt_o = drop_cnt_r;

endmodule

// File: tb/tb_axis_pgroup_router.sv
// Self-checking bench for axis_pgroup_router. Each channel is modelled as a
// queue of {tlast, tdata}. The packet state is a flag plus a target channel,
// where -1 means "discarding".
module tb_axis_pgroup_router;

    localparam int IP_AMT   = 4;
    localparam int DW       = 32;
    localparam int TDW      = 3;
    localparam int DEPTH    = 4;
    localparam int DCW      = 3;
    localparam int DROP_MAX = (1 << DCW) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [TDW-1:0]        s_tdest_i;
    logic [DW-1:0]         s_tdata_i;
    logic                  s_tlast_i;
    logic                  s_tvalid_i;
    logic                  s_tready_o;
    logic [IP_AMT*DW-1:0]  pgroup_o;
    logic [IP_AMT-1:0]     pgroup_last_o;
    logic [IP_AMT-1:0]     pgroup_valid_o;
    logic [IP_AMT-1:0]     pgroup_ready_i;
    logic [DCW-1:0]        drop_cnt_o;

    axis_pgroup_router #(
        .IP_AMT(IP_AMT), .IP_DATA_W(DW), .AXIS_TDEST_W(TDW),
        .FIFO_DEPTH(DEPTH), .DROP_CNT_W(DCW)
    ) dut (
        .clk(clk), .rst(rst), .s_tdest_i(s_tdest_i), .s_tdata_i(s_tdata_i),
        .s_tlast_i(s_tlast_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
        .pgroup_o(pgroup_o), .pgroup_last_o(pgroup_last_o),
        .pgroup_valid_o(pgroup_valid_o), .pgroup_ready_i(pgroup_ready_i),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW:0] q [IP_AMT][$];
    bit          in_pkt = 1'b0;
    int          tgt    = 0;
    int          drops  = 0;

    // Count a comparison and report it if it does not match.
    task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs against the model, then advance the model.
    task automatic step(input bit v, input int d, input logic [DW-1:0] dat, input bit l,
                        input logic [IP_AMT-1:0] rdy, input bit r, output bit accepted);
        int ch;
        bit exp_rdy;
        @(negedge clk);
        rst            = r;
        s_tvalid_i     = v;
        s_tdest_i      = TDW'(d);
        s_tdata_i      = dat;
        s_tlast_i      = l;
        pgroup_ready_i = rdy;
        #1;
        if (!in_pkt) ch = (d < IP_AMT) ? d : -1;
        else         ch = tgt;
        if (r)           exp_rdy = 1'b0;
        else if (ch < 0) exp_rdy = 1'b1;
        else             exp_rdy = (q[ch].size() < DEPTH);
        check_value("tready", 64'(s_tready_o), 64'(exp_rdy));
        for (int k = 0; k < IP_AMT; k++) begin
            check_value($sformatf("valid%0d", k), 64'(pgroup_valid_o[k]), 64'(q[k].size() != 0));
            if (q[k].size() != 0) begin
                check_value($sformatf("data%0d", k), 64'(pgroup_o[k*DW +: DW]), 64'(q[k][0][DW-1:0]));
                check_value($sformatf("last%0d", k), 64'(pgroup_last_o[k]), 64'(q[k][0][DW]));
            end
        end
        check_value("drop_cnt", 64'(drop_cnt_o), 64'(drops));
        accepted = v && exp_rdy;
        if (r) begin
            for (int k = 0; k < IP_AMT; k++) q[k].delete();
            in_pkt = 1'b0;
            drops  = 0;
        end else begin
            for (int k = 0; k < IP_AMT; k++)
                if (q[k].size() != 0 && rdy[k]) void'(q[k].pop_front());
            if (accepted) begin
                if (ch >= 0) q[ch].push_back({l, dat});
                else if (drops < DROP_MAX) drops++;
                if (l) in_pkt = 1'b0;
                else begin
                    in_pkt = 1'b1;
                    tgt    = ch;
                end
            end
        end
    endtask

    // Hold one beat until the model says it was accepted, within a bounded number of cycles.
    task automatic send_beat(input int d, input logic [DW-1:0] dat, input bit l, input logic [IP_AMT-1:0] rdy);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, d, dat, l, rdy, 1'b0, acc);
            n++;
        end
        check_value("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n, input logic [IP_AMT-1:0] rdy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 0, {DW{1'b0}}, 1'b0, rdy, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        rst = 1'b1; s_tvalid_i = 1'b0; s_tdest_i = '0; s_tdata_i = '0;
        s_tlast_i = 1'b0; pgroup_ready_i = '1;
        step(1'b0, 0, 32'd0, 1'b0, 4'hF, 1'b1, acc);
        step(1'b1, 0, 32'd0, 1'b0, 4'hF, 1'b1, acc);
        check_value("reset_valid", 64'(pgroup_valid_o), 64'd0);
        idle(1, 4'hF);

        // Single beat to channel 2: a one-cycle pulse on channel 2.
        send_beat(2, 32'h0000_00A5, 1'b1, 4'hF);
        idle(3, 4'hF);

        // A later TDEST change inside a packet is ignored.
        send_beat(1, 32'h1111_0001, 1'b0, 4'hF);
        send_beat(3, 32'h1111_0002, 1'b0, 4'hF);
        send_beat(3, 32'h1111_0003, 1'b1, 4'hF);
        idle(3, 4'hF);

        // Channel 0 stalled: four beats fill the FIFO, then ready holds low until the drain.
        for (int i = 0; i < 4; i++) send_beat(0, 32'hC0DE_0000 + 32'(i), 1'b0, 4'hE);
        for (int i = 0; i < 3; i++) step(1'b1, 0, 32'hC0DE_0004, 1'b1, 4'hE, 1'b0, acc);
        send_beat(0, 32'hC0DE_0004, 1'b1, 4'hF);
        idle(6, 4'hF);

        // Invalid destination: three beats discarded.
        for (int i = 0; i < 3; i++) send_beat(7, 32'hDEAD_0000 + 32'(i), (i == 2), 4'hF);
        idle(1, 4'hF);
        check_value("drop_cnt3", 64'(drop_cnt_o), 64'd3);
        for (int i = 0; i < 8; i++) send_beat(5, 32'hDEAD_1000 + 32'(i), 1'b1, 4'hF);
        idle(1, 4'hF);
        check_value("drop_sat", 64'(drop_cnt_o), 64'(DROP_MAX));

        // Reset mid-packet discards the buffered beat and the latched channel.
        send_beat(0, 32'hAAAA_0001, 1'b0, 4'hE);
        step(1'b1, 0, 32'hAAAA_0002, 1'b0, 4'hE, 1'b1, acc);
        idle(1, 4'hE);
        check_value("rst_ch0_empty", 64'(pgroup_valid_o[0]), 64'd0);
        check_value("rst_drop_clr", 64'(drop_cnt_o), 64'd0);
        send_beat(1, 32'hBBBB_0001, 1'b1, 4'hE);
        idle(2, 4'hF);

        // Random traffic with back-pressure, invalid destinations and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7)),
                 $urandom(), ($urandom_range(0, 3) == 0), IP_AMT'($urandom()),
                 ($urandom_range(0, 499) == 0), acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
